// File: rtl/comparator_seq.sv
// Multi-cycle magnitude/equality comparator: evaluates a - b LSB-first, W bits per cycle,
// with a carry chain, then reports EQ/NE/LT/LE/GT/GE under signed or unsigned interpretation.
module comparator_seq #(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         i_ready,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [2:0]   i_op,
    input  logic         i_signed,
    output logic         o_valid,
    input  logic         o_ready,
    output logic         o_result,
    output logic         o_lt,
    output logic         o_eq
);

    localparam int unsigned CHUNKS = N / W;
    localparam int unsigned CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHUNKS - 1);

    if (N < 2 || W < 1 || (N % W) != 0) begin : g_bad_params
        $error("comparator_seq: N must be >= 2 and an exact multiple of W");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_nx;

    logic [CHUNKS-1:0][W-1:0] a_r, b_r;
    logic [2:0]               op_r;
    logic                     sgn_r;
    logic                     carry;
    logic                     zero;
    logic [CNT_W-1:0]         cnt;

    logic [W:0] sum;
    logic       last;
    logic       ovf;
    logic       eq_nx;
    logic       lt_nx;
    logic       res_nx;

    // One chunk of a + ~b + carry; flags below are only meaningful on the last chunk.
    always_comb begin
        sum    = {1'b0, a_r[cnt]} + {1'b0, ~b_r[cnt]} + {{W{1'b0}}, carry};
        last   = (cnt == LAST);
        eq_nx  = zero & (sum[W-1:0] == '0);
        ovf    = (a_r[CHUNKS-1][W-1] ^ b_r[CHUNKS-1][W-1]) & (sum[W-1] ^ a_r[CHUNKS-1][W-1]);
        lt_nx  = sgn_r ? (sum[W-1] ^ ovf) : ~sum[W];
        res_nx = 1'b0;
        case (op_r)
            3'd0:    res_nx = eq_nx;
            3'd1:    res_nx = ~eq_nx;
            3'd2:    res_nx = lt_nx;
            3'd3:    res_nx = lt_nx | eq_nx;
            3'd4:    res_nx = ~(lt_nx | eq_nx);
            3'd5:    res_nx = ~lt_nx;
            default: res_nx = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (i_valid) state_nx = BUSY;
            BUSY:    if (last)    state_nx = DONE;
            DONE:    if (o_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r      <= '0;
            b_r      <= '0;
            op_r     <= '0;
            sgn_r    <= 1'b0;
            carry    <= 1'b0;
            zero     <= 1'b0;
            cnt      <= '0;
            o_result <= 1'b0;
            o_lt     <= 1'b0;
            o_eq     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        a_r   <= i_a;
                        b_r   <= i_b;
                        op_r  <= i_op;
                        sgn_r <= i_signed;
                        carry <= 1'b1;
                        zero  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    carry <= sum[W];
                    zero  <= eq_nx;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        o_result <= res_nx;
                        o_lt     <= lt_nx;
                        o_eq     <= eq_nx;
                    end
                end
                default: ;
            endcase
        end
    end

    assign i_ready = (state == IDLE);
    assign o_valid = (state == DONE);

endmodule

// File: tb/tb_comparator_seq.sv
// Directed bench for comparator_seq: a 32/8 instance for the multi-cycle path and a
// 16/16 instance for the single-chunk case.
module tb_comparator_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        i_valid, i_ready, o_valid, o_ready, o_result, o_lt, o_eq, i_signed;
    logic [31:0] i_a, i_b;
    logic [2:0]  i_op;

    logic        v16, r16, ov16, ordy16, res16, lt16, eq16, sgn16;
    logic [15:0] a16, b16;
    logic [2:0]  op16;

    int n_vec = 0;
    int n_err = 0;

    comparator_seq #(.N(32), .W(8)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_a(i_a), .i_b(i_b),
        .i_op(i_op), .i_signed(i_signed), .o_valid(o_valid), .o_ready(o_ready),
        .o_result(o_result), .o_lt(o_lt), .o_eq(o_eq)
    );

    comparator_seq #(.N(16), .W(16)) dut16 (
        .clk(clk), .rst(rst), .i_valid(v16), .i_ready(r16), .i_a(a16), .i_b(b16),
        .i_op(op16), .i_signed(sgn16), .o_valid(ov16), .o_ready(ordy16),
        .o_result(res16), .o_lt(lt16), .o_eq(eq16)
    );

    // Drives one request, waits (bounded) for o_valid, captures flags, then pops the result.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         input logic sgn, output int lat, output logic [2:0] flags);
        i_a = a; i_b = b; i_op = op; i_signed = sgn; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        lat = 0;
        while (o_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        flags = {o_result, o_lt, o_eq};
        o_ready = 1'b1;
        @(posedge clk); #1;
        o_ready = 1'b0;
    endtask

    task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                           input logic sgn, output int lat, output logic [2:0] flags);
        a16 = a; b16 = b; op16 = op; sgn16 = sgn; v16 = 1'b1;
        @(posedge clk); #1;
        v16 = 1'b0;
        lat = 0;
        while (ov16 !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        flags = {res16, lt16, eq16};
        ordy16 = 1'b1;
        @(posedge clk); #1;
        ordy16 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_valid = 1'b0; o_ready = 1'b0; i_a = '0; i_b = '0; i_op = '0; i_signed = 1'b0;
        v16 = 1'b0; ordy16 = 1'b0; a16 = '0; b16 = '0; op16 = '0; sgn16 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({i_ready, o_valid, o_result, o_lt, o_eq} !== 5'b10000) begin
            n_err++;
            $display("FAIL reset32: got %b want 10000", {i_ready, o_valid, o_result, o_lt, o_eq});
        end
        n_vec++;
        if ({r16, ov16, res16, lt16, eq16} !== 5'b10000) begin
            n_err++;
            $display("FAIL reset16: got %b want 10000", {r16, ov16, res16, lt16, eq16});
        end
        rst = 1'b0;
    endtask

    task automatic test_signed_neg();
        int lat;
        logic [2:0] f;
        issue(32'hFFFF_FFFF, 32'h0, 3'd2, 1'b1, lat, f);
        n_vec++;
        if (lat != 4) begin
            n_err++;
            $display("FAIL latency32: got %0d want 4", lat);
        end
        n_vec++;
        if (f !== 3'b110) begin
            n_err++;
            $display("FAIL signed_neg_lt: got %b want 110", f);
        end
    endtask

    task automatic test_unsigned();
        int lat;
        logic [2:0] f;
        issue(32'hFFFF_FFFF, 32'h0, 3'd2, 1'b0, lat, f);
        n_vec++;
        if (f !== 3'b000) begin
            n_err++;
            $display("FAIL unsigned_lt: got %b want 000", f);
        end
        issue(32'hFFFF_FFFF, 32'h0, 3'd4, 1'b0, lat, f);
        n_vec++;
        if (f !== 3'b100) begin
            n_err++;
            $display("FAIL unsigned_gt: got %b want 100", f);
        end
        issue(32'hFFFF_FFFF, 32'h0, 3'd5, 1'b0, lat, f);
        n_vec++;
        if (f !== 3'b100) begin
            n_err++;
            $display("FAIL unsigned_ge: got %b want 100", f);
        end
    endtask

    task automatic test_overflow();
        int lat;
        logic [2:0] f;
        issue(32'h8000_0000, 32'h7FFF_FFFF, 3'd2, 1'b1, lat, f);
        n_vec++;
        if (f !== 3'b110) begin
            n_err++;
            $display("FAIL ovf_min_lt_max: got %b want 110", f);
        end
        issue(32'h7FFF_FFFF, 32'h8000_0000, 3'd2, 1'b1, lat, f);
        n_vec++;
        if (f !== 3'b000) begin
            n_err++;
            $display("FAIL ovf_max_lt_min: got %b want 000", f);
        end
    endtask

    task automatic test_all_ops();
        int lat;
        logic [2:0] f;
        logic [7:0] exp_tab;
        exp_tab = 8'b0010_1001;  // bit k = expected result for op k with a == b
        for (int k = 0; k < 8; k++) begin
            issue(32'h1234_5678, 32'h1234_5678, 3'(k), 1'b0, lat, f);
            n_vec++;
            if (f !== {exp_tab[k], 1'b0, 1'b1}) begin
                n_err++;
                $display("FAIL equal_op%0d: got %b want %b", k, f, {exp_tab[k], 1'b0, 1'b1});
            end
        end
    endtask

    task automatic test_hold_stall();
        int lat;
        int bad;
        i_a = 32'd5; i_b = 32'd3; i_op = 3'd5; i_signed = 1'b0; i_valid = 1'b1;
        @(posedge clk); #1;
        // Keep requesting with different operands; none of it may be sampled.
        i_a = 32'd0; i_b = 32'd9; i_op = 3'd0;
        lat = 0;
        while (o_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        n_vec++;
        if (lat != 4) begin
            n_err++;
            $display("FAIL hold_latency: got %0d want 4", lat);
        end
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            if ({o_valid, i_ready, o_result, o_lt, o_eq} !== 5'b10100) bad++;
            @(posedge clk); #1;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL hold_stable: got %0d unstable cycles want 0", bad);
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        @(posedge clk); #1;
        o_ready = 1'b0;
        n_vec++;
        if ({o_valid, i_ready, o_result, o_lt, o_eq} !== 5'b01100) begin
            n_err++;
            $display("FAIL hold_release: got %b want 01100", {o_valid, i_ready, o_result, o_lt, o_eq});
        end
        @(posedge clk); #1;
        n_vec++;
        if ({o_valid, i_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL hold_no_accept: got %b want 01", {o_valid, i_ready});
        end
    endtask

    task automatic test_reset_busy();
        int lat;
        int seen;
        logic [2:0] f;
        i_a = 32'hFFFF_FFFF; i_b = 32'h0; i_op = 3'd2; i_signed = 1'b1; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({i_ready, o_valid, o_result} !== 3'b100) begin
            n_err++;
            $display("FAIL rst_busy_now: got %b want 100", {i_ready, o_valid, o_result});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (o_valid !== 1'b0) seen++;
            @(posedge clk); #1;
        end
        n_vec++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL rst_busy_no_valid: got %0d valid cycles want 0", seen);
        end
        issue(32'h8000_0000, 32'h7FFF_FFFF, 3'd4, 1'b1, lat, f);
        n_vec++;
        if ({lat[3:0], f} !== {4'd4, 3'b010}) begin
            n_err++;
            $display("FAIL rst_recover: got lat=%0d flags=%b want lat=4 flags=010", lat, f);
        end
    endtask

    task automatic test_full_width();
        int lat;
        logic [2:0] f;
        issue16(16'h0001, 16'hFFFF, 3'd4, 1'b1, lat, f);
        n_vec++;
        if (lat != 1) begin
            n_err++;
            $display("FAIL latency16: got %0d want 1", lat);
        end
        n_vec++;
        if (f !== 3'b100) begin
            n_err++;
            $display("FAIL w16_signed_gt: got %b want 100", f);
        end
        issue16(16'h0001, 16'hFFFF, 3'd2, 1'b0, lat, f);
        n_vec++;
        if (f !== 3'b110) begin
            n_err++;
            $display("FAIL w16_unsigned_lt: got %b want 110", f);
        end
    endtask

    initial begin
        test_reset();
        test_signed_neg();
        test_unsigned();
        test_overflow();
        test_all_ops();
        test_hold_stall();
        test_reset_busy();
        test_full_width();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
